// File: rtl/cic_interpolator_if.sv
// rtl/cic_interpolator_if.sv - sample-in / sample-out bundle of the CIC interpolator
interface cic_interpolator_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         valid_in;
  logic                         ready_out;
  logic signed [DATA_WIDTH-1:0] cic_in;
  logic signed [DATA_WIDTH-1:0] cic_out;
  logic                         valid_out;
  logic                         overflow;
  logic                         underflow;

  modport master (
    output valid_in, cic_in,
    input  ready_out, cic_out, valid_out, overflow, underflow
  );

  modport slave (
    input  valid_in, cic_in,
    output ready_out, cic_out, valid_out, overflow, underflow
  );
endinterface

// File: rtl/cic_interpolator.sv
// rtl/cic_interpolator.sv - N-stage CIC interpolator by R with normalization, gain and saturation
// Combs run at the input rate, integrators at the output rate; R output samples per accepted input.
module cic_interpolator #(
  parameter  int DATA_WIDTH        = 16,
  parameter  int DATA_FRAC         = 15,
  parameter  int N                 = 1,
  localparam int MAX_INTERP_FACTOR = 16,
  localparam int INTERP_WIDTH      = $clog2(MAX_INTERP_FACTOR)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cic_interpolator_if.slave       bus,
  input  logic                    bypass,
  input  logic [INTERP_WIDTH:0]   interp_factor,
  input  logic [2:0]              gain_shift
);
  localparam int ACC_WIDTH = DATA_WIDTH + N * INTERP_WIDTH + 1;
  localparam int EXT_WIDTH = ACC_WIDTH + 7;
  localparam int FW        = INTERP_WIDTH + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic signed [EXT_WIDTH-1:0] SAT_MAX = EXT_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [EXT_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  if (N < 1 || N > 4) begin : g_bad_n
    $error("cic_interpolator: N must be 1..4");
  end
  if (DATA_FRAC < 0 || DATA_FRAC >= DATA_WIDTH) begin : g_bad_frac
    $error("cic_interpolator: DATA_FRAC out of range");
  end

  logic [0:0]                  state;
  logic [INTERP_WIDTH-1:0]     phase;
  logic [2:0]                  r_log;
  logic [2:0]                  r_lat;
  logic [2:0]                  gain_lat;
  logic [2:0]                  out_gain;
  logic [3:0]                  norm_shift;
  logic                        flush_pend;
  logic                        int_valid;
  logic [FW-1:0]               r_val;
  logic [FW-1:0]               r_last;
  logic                        at_last;
  logic                        accept;
  logic                        r_change;

  logic signed [ACC_WIDTH-1:0] comb_prev [N];
  logic signed [ACC_WIDTH-1:0] comb_val  [N+1];
  logic signed [ACC_WIDTH-1:0] comb_reg;
  logic signed [ACC_WIDTH-1:0] integ     [N];
  logic signed [ACC_WIDTH-1:0] int_next  [N];

  logic signed [EXT_WIDTH-1:0] ext;
  logic signed [EXT_WIDTH-1:0] shifted;
  logic                        sat_hi;
  logic                        sat_lo;
  logic [DATA_WIDTH-1:0]       sat_val;

  // Anything other than an exact power of two up to 16 decodes as R=1.
  always_comb begin
    r_log = '0;
    for (int i = 0; i <= INTERP_WIDTH; i++) begin
      if (interp_factor == (FW'(1) << i)) r_log = 3'(i);
    end
  end

  assign r_val         = FW'(1) << r_lat;
  assign r_last        = r_val - FW'(1);
  assign at_last       = ({1'b0, phase} == r_last);
  assign bus.ready_out = bypass | (state == IDLE) | at_last;
  assign accept        = bus.valid_in & bus.ready_out;
  assign r_change      = (r_log != r_lat);

  // On a rate change the comb history is treated as zero for this sample.
  always_comb begin
    comb_val[0] = ACC_WIDTH'(bus.cic_in);
    for (int i = 0; i < N; i++) begin
      comb_val[i+1] = comb_val[i] - (r_change ? '0 : comb_prev[i]);
    end
  end

  always_comb begin
    int_next[0] = (flush_pend ? '0 : integ[0]) + ((phase == '0) ? comb_reg : '0);
    for (int i = 1; i < N; i++) begin
      int_next[i] = (flush_pend ? '0 : integ[i]) + int_next[i-1];
    end
  end

  always_comb begin
    ext     = EXT_WIDTH'(integ[N-1]);
    shifted = (ext >>> norm_shift) <<< out_gain;
    sat_hi  = (shifted > SAT_MAX);
    sat_lo  = (shifted < SAT_MIN);
    if (sat_hi)      sat_val = SAT_MAX[DATA_WIDTH-1:0];
    else if (sat_lo) sat_val = SAT_MIN[DATA_WIDTH-1:0];
    else             sat_val = shifted[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= '0;
      r_lat      <= '0;
      gain_lat   <= '0;
      out_gain   <= '0;
      norm_shift <= '0;
      flush_pend <= 1'b0;
      int_valid  <= 1'b0;
      comb_reg   <= '0;
      for (int i = 0; i < N; i++) begin
        comb_prev[i] <= '0;
        integ[i]     <= '0;
      end
    end else if (bypass) begin
      state      <= IDLE;
      phase      <= '0;
      flush_pend <= 1'b0;
      int_valid  <= 1'b0;
      comb_reg   <= '0;
      for (int i = 0; i < N; i++) begin
        comb_prev[i] <= '0;
        integ[i]     <= '0;
      end
    end else begin
      int_valid <= (state == RUN);
      // Gain and normalization travel with the integrator value so a back-to-back
      // accept cannot retune the tail of the previous sample.
      if (state == RUN) begin
        for (int i = 0; i < N; i++) integ[i] <= int_next[i];
        flush_pend <= 1'b0;
        out_gain   <= gain_lat;
        norm_shift <= 4'((N - 1) * r_lat);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state <= RUN;
            phase <= '0;
          end
        end
        default: begin
          if (at_last) begin
            phase <= '0;
            if (!accept) state <= IDLE;
          end else begin
            phase <= phase + 1'b1;
          end
        end
      endcase
      if (accept) begin
        r_lat      <= r_log;
        gain_lat   <= gain_shift;
        flush_pend <= r_change;
        comb_reg   <= comb_val[N];
        for (int i = 0; i < N; i++) comb_prev[i] <= comb_val[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.cic_out   <= '0;
      bus.valid_out <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else if (bypass) begin
      bus.valid_out <= accept;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
      if (accept) bus.cic_out <= bus.cic_in;
    end else if (int_valid) begin
      bus.cic_out   <= sat_val;
      bus.valid_out <= 1'b1;
      bus.overflow  <= sat_hi;
      bus.underflow <= sat_lo;
    end else begin
      bus.valid_out <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cic_interpolator.sv
// tb/tb_cic_interpolator.sv - checks N=1 and N=2 instances against a sample-level CIC model
module tb_cic_interpolator;
  localparam int SZ = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        bypass = 1'b0;
  logic [15:0] cic_in = '0;
  logic [4:0]  interp_factor = 5'd1;
  logic [2:0]  gain_shift = '0;

  cic_interpolator_if #(.DATA_WIDTH(16)) b1 ();
  cic_interpolator_if #(.DATA_WIDTH(16)) b2 ();

  assign b1.valid_in = valid_in;
  assign b1.cic_in   = cic_in;
  assign b2.valid_in = valid_in;
  assign b2.cic_in   = cic_in;

  cic_interpolator #(.DATA_WIDTH(16), .DATA_FRAC(15), .N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .bypass(bypass),
    .interp_factor(interp_factor), .gain_shift(gain_shift)
  );
  cic_interpolator #(.DATA_WIDTH(16), .DATA_FRAC(15), .N(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2), .bypass(bypass),
    .interp_factor(interp_factor), .gain_shift(gain_shift)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  int busy_edge = 0;
  int rlat = 1;

  logic        ev [2][SZ];
  logic [15:0] ed [2][SZ];
  logic        eo [2][SZ];
  logic        eu [2][SZ];
  logic        rchk [SZ];
  longint      cprev [2][4];
  longint      integ [2][4];
  logic [15:0] q1 [$];
  logic [15:0] q2 [$];
  logic [15:0] expq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint wrap(input longint v, input int w);
    longint t;
    t = v <<< (64 - w);
    return t >>> (64 - w);
  endfunction

  function automatic int legal_r(input logic [4:0] f);
    if (f inside {5'd1, 5'd2, 5'd4, 5'd8, 5'd16}) return int'(f);
    return 1;
  endfunction

  task automatic clear_state();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        cprev[k][i] = 0;
        integ[k][i] = 0;
      end
  endtask

  task automatic clear_sched(input int from);
    for (int t = from; t < from + 40 && t < SZ; t++) begin
      rchk[t] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        ev[k][t] = 1'b0; ed[k][t] = '0; eo[k][t] = 1'b0; eu[k][t] = 1'b0;
      end
    end
  endtask

  // Whole-sample model: comb once, then R zero-stuffed integrator steps, all at accept time.
  task automatic model_accept(input int e, input logic [15:0] d);
    int r, lg, w, sh, t;
    longint x, y, u, o;
    r = legal_r(interp_factor);
    lg = 0;
    while ((1 << lg) < r) lg++;
    if (r != rlat) clear_state();
    rlat = r;
    for (int k = 0; k < 2; k++) begin
      w  = 16 + (k + 1) * 4 + 1;
      sh = k * lg;
      x  = longint'($signed(d));
      for (int i = 0; i <= k; i++) begin
        y = wrap(x - cprev[k][i], w);
        cprev[k][i] = x;
        x = y;
      end
      for (int p = 0; p < r; p++) begin
        u = (p == 0) ? x : 0;
        for (int i = 0; i <= k; i++) begin
          integ[k][i] = wrap(integ[k][i] + u, w);
          u = integ[k][i];
        end
        o = (u >>> sh) <<< gain_shift;
        t = e + 2 + p;
        ev[k][t] = 1'b1; eo[k][t] = 1'b0; eu[k][t] = 1'b0;
        if (o > 32767) begin
          ed[k][t] = 16'h7FFF; eo[k][t] = 1'b1;
        end else if (o < -32768) begin
          ed[k][t] = 16'h8000; eu[k][t] = 1'b1;
        end else begin
          ed[k][t] = o[15:0];
        end
      end
    end
  endtask

  task automatic check_outputs(input int e);
    logic v, o, u;
    logic [15:0] d;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        v = b1.valid_out; d = b1.cic_out; o = b1.overflow; u = b1.underflow;
      end else begin
        v = b2.valid_out; d = b2.cic_out; o = b2.overflow; u = b2.underflow;
      end
      chk($sformatf("valid_out[n%0d,e%0d]", k + 1, e), {31'd0, v}, {31'd0, ev[k][e]});
      if (ev[k][e]) begin
        chk($sformatf("cic_out[n%0d,e%0d]", k + 1, e), {16'd0, d}, {16'd0, ed[k][e]});
        chk($sformatf("overflow[n%0d,e%0d]", k + 1, e), {31'd0, o}, {31'd0, eo[k][e]});
        chk($sformatf("underflow[n%0d,e%0d]", k + 1, e), {31'd0, u}, {31'd0, eu[k][e]});
      end else begin
        chk($sformatf("idle_flags[n%0d,e%0d]", k + 1, e), {30'd0, o, u}, 32'd0);
        if (rchk[e]) chk($sformatf("reset_out[n%0d]", k + 1), {16'd0, d}, 32'd0);
      end
      if (v === 1'b1) begin
        if (k == 0) q1.push_back(d);
        else        q2.push_back(d);
      end
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d, output logic acc);
    int e;
    logic exp_ready;
    valid_in = v;
    cic_in   = d;
    #1;
    e = edge_n + 1;
    exp_ready = bypass || (e >= busy_edge);
    if (rst_n) begin
      chk($sformatf("ready_out[n1,e%0d]", e), {31'd0, b1.ready_out}, {31'd0, exp_ready});
      chk($sformatf("ready_out[n2,e%0d]", e), {31'd0, b2.ready_out}, {31'd0, exp_ready});
    end
    acc = rst_n && v && exp_ready;
    if (!rst_n) begin
      clear_state();
      rlat = 1;
      busy_edge = 0;
      clear_sched(e);
      rchk[e] = 1'b1;
    end else if (bypass) begin
      clear_state();
      busy_edge = e;
      clear_sched(e);
      if (acc) begin
        ev[0][e] = 1'b1; ed[0][e] = d;
        ev[1][e] = 1'b1; ed[1][e] = d;
      end
    end else if (acc) begin
      busy_edge = e + legal_r(interp_factor);
      model_accept(e, d);
    end
    @(posedge clk);
    #1;
    edge_n = e;
    check_outputs(e);
  endtask

  task automatic send(input logic [15:0] d);
    logic acc;
    int n;
    n = 0;
    do begin
      step(1'b1, d, acc);
      n++;
    end while (!acc && n < 64);
    if (!acc) begin
      tests++;
      fails++;
      $error("FAIL accept_timeout observed=no_accept expected=accept within 64 cycles");
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, acc);
  endtask

  task automatic do_reset();
    logic acc;
    rst_n = 1'b0;
    step(1'b1, 16'h5A5A, acc);
    rst_n = 1'b1;
  endtask

  task automatic check_q(input int k, input string tag);
    int sz;
    sz = (k == 0) ? q1.size() : q2.size();
    chk({tag, "_count"}, 32'(sz), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      if (i < sz) chk($sformatf("%s_%0d", tag, i), {16'd0, (k == 0) ? q1[i] : q2[i]}, {16'd0, expq[i]});
    end
  endtask

  initial begin
    logic acc;
    for (int t = 0; t < SZ; t++) begin
      rchk[t] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        ev[k][t] = 1'b0; ed[k][t] = '0; eo[k][t] = 1'b0; eu[k][t] = 1'b0;
      end
    end
    clear_state();

    do_reset();
    do_reset();

    interp_factor = 5'd4; gain_shift = 3'd0;
    q1.delete();
    send(16'h1000);
    send(16'h2000);
    idle(8);
    expq = {16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h2000, 16'h2000, 16'h2000, 16'h2000};
    check_q(0, "n1_r4_pair");

    do_reset();
    interp_factor = 5'd2;
    q2.delete();
    send(16'h2000);
    send(16'h2000);
    idle(6);
    expq = {16'h1000, 16'h2000, 16'h2000, 16'h2000};
    check_q(1, "n2_r2_pair");

    do_reset();
    interp_factor = 5'd2; gain_shift = 3'd1;
    q1.delete();
    send(16'h4000);
    idle(5);
    expq = {16'h7FFF, 16'h7FFF};
    check_q(0, "sat_pos");
    do_reset();
    q1.delete();
    send(16'hB000);
    idle(5);
    expq = {16'h8000, 16'h8000};
    check_q(0, "sat_neg");

    do_reset();
    gain_shift = 3'd0; interp_factor = 5'd6;
    q1.delete();
    send(16'h0123);
    idle(4);
    expq = {16'h0123};
    check_q(0, "illegal_r");

    do_reset();
    interp_factor = 5'd8;
    send(16'h1234);
    idle(3);
    do_reset();
    q1.delete();
    send(16'h0100);
    idle(12);
    expq = {16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};
    check_q(0, "after_reset");

    bypass = 1'b1;
    q1.delete();
    send(16'h7FFF);
    send(16'h8000);
    send(16'h0001);
    idle(2);
    expq = {16'h7FFF, 16'h8000, 16'h0001};
    check_q(0, "bypass");
    bypass = 1'b0;

    interp_factor = 5'd16;
    send(16'h0500);
    idle(3);
    bypass = 1'b1;
    idle(2);
    bypass = 1'b0;

    interp_factor = 5'd4;
    send(16'h0300);
    idle(6);
    q1.delete();
    interp_factor = 5'd2;
    send(16'h0777);
    idle(4);
    expq = {16'h0777, 16'h0777};
    check_q(0, "r_change_flush");

    for (int it = 0; it < 500; it++) begin
      logic [4:0] ftab [8];
      ftab[0] = 5'd1; ftab[1] = 5'd2; ftab[2] = 5'd4; ftab[3] = 5'd8;
      ftab[4] = 5'd16; ftab[5] = 5'd6; ftab[6] = 5'd0; ftab[7] = 5'd3;
      rst_n = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 19) == 0) bypass = ~bypass;
      interp_factor = ftab[$urandom_range(0, 7)];
      gain_shift = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      step($urandom_range(0, 3) != 0, 16'($urandom), acc);
    end
    rst_n = 1'b1;
    bypass = 1'b0;
    idle(24);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
